// File: rtl/load_req_sequencer_if.sv
// Pipeline-side and memory-side handshake bundle for the load request sequencer.
interface load_req_sequencer_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64
);
  logic                  i_flush;
  logic                  i_req_valid;
  logic                  o_req_ready;
  logic [2:0]            i_func3;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic                  o_mem_req_valid;
  logic                  i_mem_req_ready;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic                  i_mem_rsp_valid;
  logic [DATA_WIDTH-1:0] i_mem_rsp_data;
  logic                  i_mem_rsp_err;
  logic                  o_rsp_valid;
  logic [DATA_WIDTH-1:0] o_rsp_data;
  logic                  o_load_addr_ma;
  logic                  o_load_access_fault;
  logic                  o_load_illegal;
  logic                  o_busy;

  modport slave (
    input  i_flush, i_req_valid, i_func3, i_addr, i_mem_req_ready,
           i_mem_rsp_valid, i_mem_rsp_data, i_mem_rsp_err,
    output o_req_ready, o_mem_req_valid, o_mem_addr, o_rsp_valid, o_rsp_data,
           o_load_addr_ma, o_load_access_fault, o_load_illegal, o_busy
  );

  modport master (
    output i_flush, i_req_valid, i_func3, i_addr, i_mem_req_ready,
           i_mem_rsp_valid, i_mem_rsp_data, i_mem_rsp_err,
    input  o_req_ready, o_mem_req_valid, o_mem_addr, o_rsp_valid, o_rsp_data,
           o_load_addr_ma, o_load_access_fault, o_load_illegal, o_busy
  );
endinterface

// File: rtl/load_req_sequencer.sv
// Issues one load at a time to a 64-bit read port, filters misaligned/illegal
// loads, times out silent memory and returns the extended result.
module load_req_sequencer #(
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 i_clk,
  input  logic                 i_arst_n,
  load_req_sequencer_if.slave  bus
);
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN, S_DONE} state_t;

  state_t                state, state_nxt;
  logic [2:0]            func3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  ma_q, af_q, ill_q;

  logic req_ready, accept, acc_ma, acc_ill, timeout, rsp_in;

  function automatic logic [DATA_WIDTH-1:0] fmt(input logic [2:0] f3, input logic [2:0] off,
                                                input logic [DATA_WIDTH-1:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;
    b = d[8*off +: 8];
    h = d[16*off[2:1] +: 16];
    w = off[2] ? d[63:32] : d[31:0];
    case (f3)
      3'b000:  fmt = {{(DATA_WIDTH-8){b[7]}}, b};
      3'b001:  fmt = {{(DATA_WIDTH-16){h[15]}}, h};
      3'b010:  fmt = {{(DATA_WIDTH-32){w[31]}}, w};
      3'b011:  fmt = d;
      3'b100:  fmt = {{(DATA_WIDTH-8){1'b0}}, b};
      3'b101:  fmt = {{(DATA_WIDTH-16){1'b0}}, h};
      3'b110:  fmt = {{(DATA_WIDTH-32){1'b0}}, w};
      default: fmt = '0;
    endcase
  endfunction

  assign req_ready = (state == S_IDLE) & ~bus.i_flush;
  assign accept    = bus.i_req_valid & req_ready;
  assign acc_ill   = (bus.i_func3 == 3'b111);
  assign timeout   = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign rsp_in    = bus.i_mem_rsp_valid;

  always_comb begin
    acc_ma = 1'b0;
    case (bus.i_func3)
      3'b001, 3'b101: acc_ma = bus.i_addr[0];
      3'b010, 3'b110: acc_ma = |bus.i_addr[1:0];
      3'b011:         acc_ma = |bus.i_addr[2:0];
      default:        acc_ma = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) state <= S_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt           = state;
    bus.o_req_ready     = req_ready;
    bus.o_mem_req_valid = 1'b0;
    bus.o_rsp_valid     = 1'b0;
    bus.o_busy          = (state != S_IDLE);
    case (state)
      S_IDLE:  if (accept) state_nxt = (acc_ma | acc_ill) ? S_DONE : S_REQ;
      S_REQ: begin
        // flush wins over the handshake, so valid drops with it
        bus.o_mem_req_valid = ~bus.i_flush;
        if (bus.i_flush)              state_nxt = S_IDLE;
        else if (bus.i_mem_req_ready) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (bus.i_flush)            state_nxt = (rsp_in | timeout) ? S_IDLE : S_DRAIN;
        else if (rsp_in | timeout)  state_nxt = S_DONE;
      end
      S_DRAIN: if (rsp_in | timeout) state_nxt = S_IDLE;
      S_DONE: begin
        bus.o_rsp_valid = ~bus.i_flush;
        state_nxt       = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      func3_q <= '0;
      addr_q  <= '0;
      cnt     <= '0;
      data_q  <= '0;
      ma_q    <= 1'b0;
      af_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          func3_q <= bus.i_func3;
          addr_q  <= bus.i_addr;
          ill_q   <= acc_ill;
          ma_q    <= acc_ma & ~acc_ill;
          af_q    <= 1'b0;
          data_q  <= '0;
        end
        S_REQ: if (!bus.i_flush && bus.i_mem_req_ready) cnt <= '0;
        S_WAIT, S_DRAIN: begin
          cnt <= cnt + 1'b1;
          // a response in the timeout cycle still counts as the real answer
          if (rsp_in) begin
            af_q   <= bus.i_mem_rsp_err;
            data_q <= bus.i_mem_rsp_err ? '0 : fmt(func3_q, addr_q[2:0], bus.i_mem_rsp_data);
          end else if (timeout) begin
            af_q   <= 1'b1;
            data_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_mem_addr          = {addr_q[ADDR_WIDTH-1:3], 3'b000};
  assign bus.o_rsp_data          = data_q;
  assign bus.o_load_addr_ma      = ma_q;
  assign bus.o_load_access_fault = af_q;
  assign bus.o_load_illegal      = ill_q;
endmodule

// File: tb/tb_load_req_sequencer.sv
// Randomized scoreboard bench: the driver pushes reference results, a monitor
// pops one on every o_rsp_valid and compares data, flags and arrival cycle.
module tb_load_req_sequencer;
  localparam int T = 4;

  logic i_clk = 1'b0;
  logic i_arst_n = 1'b0;

  load_req_sequencer_if #(.DATA_WIDTH(64), .ADDR_WIDTH(64)) bus();

  load_req_sequencer #(.DATA_WIDTH(64), .ADDR_WIDTH(64), .TIMEOUT_CYCLES(T)) dut (
    .i_clk(i_clk), .i_arst_n(i_arst_n), .bus(bus)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] data;
    bit          ma, af, ill;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: shift the selected bytes down, mask to size, extend by func3.
  function automatic exp_t ref_model(input logic [2:0] f3, input logic [63:0] a,
                                     input logic [63:0] d64, input bit err, input bit tmo);
    exp_t e;
    int sz, off;
    logic [63:0] v, mask;
    off   = int'(a[2:0]);
    sz    = 1 << f3[1:0];
    e.ill = (f3 == 3'b111);
    e.ma  = !e.ill && ((off % sz) != 0);
    e.af  = !e.ill && !e.ma && (tmo || err);
    e.cyc = 0;
    v = d64 >> (8 * off);
    if (sz < 8) begin
      mask = (64'd1 << (8 * sz)) - 64'd1;
      v = v & mask;
      if (!f3[2] && v[8*sz-1]) v = v | ~mask;
    end
    e.data = (e.ill || e.ma || e.af) ? 64'd0 : v;
    return e;
  endfunction

  always @(negedge i_clk) begin
    if (bus.o_rsp_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp: got o_rsp_valid=1 at cycle %0d expected none", cyc);
      end else begin
        mon_e = sbq.pop_front();
        chk("rsp_cycle", 64'(cyc), 64'(mon_e.cyc));
        chk("rsp_data", bus.o_rsp_data, mon_e.data);
        chk("rsp_ma", 64'(bus.o_load_addr_ma), 64'(mon_e.ma));
        chk("rsp_af", 64'(bus.o_load_access_fault), 64'(mon_e.af));
        chk("rsp_ill", 64'(bus.o_load_illegal), 64'(mon_e.ill));
      end
    end
  end

  // mode: 0 normal, 1 flush in REQ, 2 flush in first WAIT cycle, 3 reset in WAIT.
  // r = REQ cycles before mem ready, d = WAIT/DRAIN cycle index of the response.
  task automatic do_load(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] d64,
                         input bit err, input int r, input int d, input int mode);
    exp_t e;
    int n, m, k;
    bit exc;
    k = 0;
    while (bus.o_req_ready !== 1'b1 && k < 20) begin @(negedge i_clk); k++; end
    if (bus.o_req_ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL req_ready_wait: got 0 expected 1 within 20 cycles");
      return;
    end
    n = cyc;
    m = (d < T - 1) ? d : T - 1;
    e = ref_model(f3, a, d64, err, d >= T);
    exc = e.ill || e.ma;
    e.cyc = exc ? n + 1 : n + 3 + r + m;
    if (exc || mode == 0) sbq.push_back(e);
    #1;
    bus.i_req_valid = 1'b1;
    bus.i_func3     = f3;
    bus.i_addr      = a;
    @(negedge i_clk);
    if (exc) begin
      chk("exc_no_mem_req", 64'(bus.o_mem_req_valid), 64'd0);
      #1 bus.i_req_valid = 1'b0;
      @(negedge i_clk);
      chk("exc_no_mem_req2", 64'(bus.o_mem_req_valid), 64'd0);
      chk("exc_idle", 64'(bus.o_busy), 64'd0);
      return;
    end
    chk("mem_req_valid", 64'(bus.o_mem_req_valid), 64'd1);
    chk("mem_addr", bus.o_mem_addr, {a[63:3], 3'b000});
    if (mode == 1) begin
      #1;
      bus.i_req_valid     = 1'b0;
      bus.i_flush         = 1'b1;
      bus.i_mem_req_ready = 1'b1;
      #1 chk("flush_req_drop", 64'(bus.o_mem_req_valid), 64'd0);
      @(negedge i_clk);
      chk("flush_req_idle", 64'(bus.o_busy), 64'd0);
      #1;
      bus.i_flush         = 1'b0;
      bus.i_mem_req_ready = 1'b0;
      @(negedge i_clk);
      return;
    end
    for (int i = 0; i <= r; i++) begin
      #1;
      bus.i_req_valid     = 1'b0;
      bus.i_mem_req_ready = (i == r);
      @(negedge i_clk);
    end
    for (int j = 0; j <= m; j++) begin
      #1;
      bus.i_mem_req_ready = 1'b0;
      bus.i_mem_rsp_valid = (j == d);
      bus.i_mem_rsp_data  = d64;
      bus.i_mem_rsp_err   = err;
      bus.i_flush         = (mode == 2 && j == 0);
      if (mode == 3) begin
        #1 i_arst_n = 1'b0;
        #1;
        chk("arst_mem_req_valid", 64'(bus.o_mem_req_valid), 64'd0);
        chk("arst_rsp_valid", 64'(bus.o_rsp_valid), 64'd0);
        chk("arst_busy", 64'(bus.o_busy), 64'd0);
        chk("arst_req_ready", 64'(bus.o_req_ready), 64'd1);
        chk("arst_rsp_data", bus.o_rsp_data, 64'd0);
        bus.i_mem_rsp_valid = 1'b1;
        @(negedge i_clk);
        #1 i_arst_n = 1'b1;
        @(negedge i_clk);
        chk("stale_rsp_busy", 64'(bus.o_busy), 64'd0);
        chk("stale_rsp_ready", 64'(bus.o_req_ready), 64'd1);
        #1 bus.i_mem_rsp_valid = 1'b0;
        @(negedge i_clk);
        return;
      end
      @(negedge i_clk);
    end
    if (mode == 2) chk("drain_idle", 64'(bus.o_busy), 64'd0);
    #1;
    bus.i_mem_rsp_valid = 1'b0;
    bus.i_mem_rsp_err   = 1'b0;
    bus.i_flush         = 1'b0;
    @(negedge i_clk);
    chk("post_idle", 64'(bus.o_busy), 64'd0);
  endtask

  initial begin
    bus.i_flush = 0; bus.i_req_valid = 0; bus.i_func3 = 0; bus.i_addr = 0;
    bus.i_mem_req_ready = 0; bus.i_mem_rsp_valid = 0; bus.i_mem_rsp_data = 0; bus.i_mem_rsp_err = 0;
    #2;
    chk("rst_busy", 64'(bus.o_busy), 64'd0);
    chk("rst_mem_req_valid", 64'(bus.o_mem_req_valid), 64'd0);
    chk("rst_rsp_valid", 64'(bus.o_rsp_valid), 64'd0);
    chk("rst_req_ready", 64'(bus.o_req_ready), 64'd1);
    repeat (2) @(negedge i_clk);
    #1 i_arst_n = 1'b1;
    @(negedge i_clk);
    #1 bus.i_flush = 1'b1;
    #1 chk("flush_blocks_ready", 64'(bus.o_req_ready), 64'd0);
    bus.i_flush = 1'b0;
    @(negedge i_clk);

    do_load(3'b010, 64'h1004, 64'h80000001_12345678, 0, 0, 0, 0);
    do_load(3'b100, 64'h2007, 64'hAB000000_00000000, 0, 0, 0, 0);
    do_load(3'b000, 64'h2007, 64'hAB000000_00000000, 0, 0, 0, 0);
    do_load(3'b011, 64'h2000, 64'hAB000000_00000000, 0, 1, 2, 0);
    do_load(3'b001, 64'h3003, 64'h0, 0, 0, 0, 0);
    do_load(3'b111, 64'h3000, 64'h0, 0, 0, 0, 0);
    do_load(3'b011, 64'h4000, 64'h1, 0, 0, T, 0);
    do_load(3'b011, 64'h4000, 64'h1, 0, 0, T + 2, 0);
    do_load(3'b011, 64'h4008, 64'h2, 1, 0, 1, 0);
    do_load(3'b011, 64'h4010, 64'h3, 0, 0, T - 1, 0);
    do_load(3'b010, 64'h5000, 64'h11, 0, 0, 3, 2);
    do_load(3'b010, 64'h5004, 64'h00000007_FFFFFFFE, 0, 0, 0, 0);
    do_load(3'b011, 64'h5008, 64'h22, 0, 0, 0, 1);
    do_load(3'b110, 64'h6004, 64'h80000000_00000000, 0, 0, 0, 0);
    do_load(3'b011, 64'h7000, 64'h33, 0, 0, 0, 3);
    #1 bus.i_mem_rsp_valid = 1'b1;
    @(negedge i_clk);
    chk("idle_ignore_rsp", 64'(bus.o_busy), 64'd0);
    #1 bus.i_mem_rsp_valid = 1'b0;
    @(negedge i_clk);

    for (int t = 0; t < 300; t++) begin
      logic [2:0]  f3;
      logic [63:0] a, d64;
      int r, d, mode;
      f3  = 3'($urandom_range(0, 7));
      a   = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) a[2:0] = 3'b000;
      d64 = {$urandom, $urandom};
      r   = $urandom_range(0, 2);
      d   = $urandom_range(0, T + 1);
      mode = 0;
      if ($urandom_range(0, 9) == 0) mode = 1;
      else if ($urandom_range(0, 7) == 0 && d >= 1) mode = 2;
      do_load(f3, a, d64, ($urandom_range(0, 7) == 0), r, d, mode);
    end

    repeat (5) @(negedge i_clk);
    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: got no completion expected finish before 2000000");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
